branch_logic: RTL and testbench

- Branch-resolution unit of the RISC datapath.
- Decodes opcode/FnCode of the instruction in the decode/execute stage against the registered ALU flags (Z, O, C, S).
- Produces a registered branch-taken strobe and the 16-bit PC offset/target consumed by the PC-update logic on the next cycle.

---
 rtl/branch_logic_if.sv | 26 ++
 rtl/branch_logic.sv | 74 +++++++
 tb/tb_branch_logic.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/branch_logic_if.sv
// Instruction/flag inputs and registered branch outputs shared between
// the decode/execute stage and the branch-resolution unit.
interface branch_logic_if;
    logic [3:0]  opcode;
    logic [3:0]  FnCode;
    logic [15:0] offset_in;
    logic [31:0] rs_value;
    logic        zflag_ff;
    logic        oflag_ff;
    logic        cflag_ff;
    logic        sflag_ff;
    logic [15:0] offset_out;
    logic        branch;

    modport master (
        output opcode, FnCode, offset_in, rs_value,
        output zflag_ff, oflag_ff, cflag_ff, sflag_ff,
        input  offset_out, branch
    );

    modport slave (
        input  opcode, FnCode, offset_in, rs_value,
        input  zflag_ff, oflag_ff, cflag_ff, sflag_ff,
        output offset_out, branch
    );
endinterface

// File: rtl/branch_logic.sv
// Branch-resolution unit: decodes jump/branch opcodes against the registered
// ALU flags and registers the taken strobe plus PC offset/target.
module branch_logic #(
    parameter logic [3:0] JMP_OP = 4'b0110,
    parameter logic [3:0] BR_OP  = 4'b0111
) (
    input  logic           clk,
    input  logic           rst,
    branch_logic_if.slave  bus
);

    typedef enum logic [3:0] {
        COND_Z  = 4'b0000,
        COND_NZ = 4'b0001,
        COND_C  = 4'b0010,
        COND_NC = 4'b0011,
        COND_S  = 4'b0100,
        COND_NS = 4'b0101,
        COND_O  = 4'b0110,
        COND_NO = 4'b0111
    } cond_e;

    logic        w_take;
    logic [15:0] w_offset;
    logic        r_branch;
    logic [15:0] r_offset;
    logic        w_unused_rs_hi;

    // Only the low half of rs_value forms the register-jump target.
    assign w_unused_rs_hi = ^bus.rs_value[31:16];

    always_comb begin
        w_take   = 1'b0;
        w_offset = '0;
        if (bus.opcode == JMP_OP) begin
            if (bus.FnCode == 4'b0000) begin
                w_take   = 1'b1;
                w_offset = bus.offset_in;
            end else if (bus.FnCode == 4'b0001) begin
                w_take   = 1'b1;
                w_offset = bus.rs_value[15:0];
            end
        end else if (bus.opcode == BR_OP) begin
            case (bus.FnCode)
                COND_Z:  w_take = bus.zflag_ff;
                COND_NZ: w_take = ~bus.zflag_ff;
                COND_C:  w_take = bus.cflag_ff;
                COND_NC: w_take = ~bus.cflag_ff;
                COND_S:  w_take = bus.sflag_ff;
                COND_NS: w_take = ~bus.sflag_ff;
                COND_O:  w_take = bus.oflag_ff;
                COND_NO: w_take = ~bus.oflag_ff;
                default: w_take = 1'b0;
            endcase
            if (w_take) begin
                w_offset = bus.offset_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_branch <= 1'b0;
            r_offset <= '0;
        end else begin
            r_branch <= w_take;
            r_offset <= w_offset;
        end
    end

    assign bus.branch     = r_branch;
    assign bus.offset_out = r_offset;

endmodule

// File: tb/tb_branch_logic.sv
// Scoreboard bench for branch_logic: directed vectors push expected results,
// an independent monitor pops and compares one entry per clock edge.
module tb_branch_logic;

    logic clk;
    logic rst;

    branch_logic_if bus ();

    branch_logic #(
        .JMP_OP (4'b0110),
        .BR_OP  (4'b0111)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        br;
        logic [15:0] off;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic [3:0] op, input logic [3:0] fn,
                         input logic [15:0] off, input logic [31:0] rs,
                         input logic z, input logic o, input logic c, input logic s);
        rst           = r;
        bus.opcode    = op;
        bus.FnCode    = fn;
        bus.offset_in = off;
        bus.rs_value  = rs;
        bus.zflag_ff  = z;
        bus.oflag_ff  = o;
        bus.cflag_ff  = c;
        bus.sflag_ff  = s;
    endtask

    task automatic expect_out(input logic br, input logic [15:0] off, input string name);
        exp_t e;
        e.br   = br;
        e.off  = off;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic vec(input logic r, input logic [3:0] op, input logic [3:0] fn,
                       input logic [15:0] off, input logic [31:0] rs,
                       input logic z, input logic o, input logic c, input logic s,
                       input logic ebr, input logic [15:0] eoff, input string name);
        @(negedge clk);
        drive(r, op, fn, off, rs, z, o, c, s);
        expect_out(ebr, eoff, name);
    endtask

    // Outputs checked 1 ns after each edge, then again mid-cycle to prove they hold.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                checks++;
                if (bus.branch !== e.br || bus.offset_out !== e.off) begin
                    errors++;
                    $display("FAIL %s: got branch=%b offset_out=%h, expected branch=%b offset_out=%h",
                             e.name, bus.branch, bus.offset_out, e.br, e.off);
                end
                #3;
                checks++;
                if (bus.branch !== e.br || bus.offset_out !== e.off) begin
                    errors++;
                    $display("FAIL %s_hold: got branch=%b offset_out=%h, expected branch=%b offset_out=%h",
                             e.name, bus.branch, bus.offset_out, e.br, e.off);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst   op     fn     off       rs             z     o     c     s     br    eoff
        vec(1'b0, 4'h6, 4'h0, 16'h0004, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset");
        vec(1'b1, 4'h6, 4'h0, 16'h0004, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, "reset_release_jmp");
        vec(1'b1, 4'h6, 4'h0, 16'h0004, 32'hFFFFFFE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, "jmp_rel");
        vec(1'b1, 4'h6, 4'h1, 16'h0004, 32'hFFFFFFE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFE0, "jmp_reg");
        vec(1'b1, 4'h6, 4'h1, 16'h0004, 32'h5A5A1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, "jmp_reg_hi_ignored");
        vec(1'b1, 4'h6, 4'h2, 16'h0004, 32'h0000FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "jmp_bad_fn");
        vec(1'b1, 4'h7, 4'h0, 16'h000A, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, "br_z_taken");
        vec(1'b1, 4'h7, 4'h0, 16'h000A, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "br_z_not");
        vec(1'b1, 4'h7, 4'h1, 16'h0003, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, "br_nz_taken");
        vec(1'b1, 4'h7, 4'h4, 16'h0005, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, "br_s_taken");
        vec(1'b1, 4'h7, 4'h4, 16'h0006, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "br_s_not");
        vec(1'b1, 4'h7, 4'h5, 16'h0007, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, "br_ns_taken");
        vec(1'b1, 4'h7, 4'h2, 16'h0008, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0008, "br_c_taken");
        vec(1'b1, 4'h7, 4'h3, 16'h0008, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, "br_nc_taken");
        vec(1'b1, 4'h7, 4'h3, 16'h0008, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "br_nc_not");
        vec(1'b1, 4'h7, 4'h6, 16'h0009, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0009, "br_o_taken");
        vec(1'b1, 4'h7, 4'h7, 16'h0009, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "br_no_not");
        vec(1'b1, 4'h7, 4'h7, 16'h000B, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000B, "br_no_taken");
        vec(1'b1, 4'h7, 4'hA, 16'h000C, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "br_fn1010");
        vec(1'b1, 4'h7, 4'hF, 16'h000C, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "br_fn1111");
        vec(1'b1, 4'h7, 4'h8, 16'h000C, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "br_fn1000");
        vec(1'b1, 4'h0, 4'h0, 16'h000D, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "op0000");
        vec(1'b1, 4'hF, 4'h0, 16'h000D, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "op1111");
        vec(1'b0, 4'h7, 4'h0, 16'h0010, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset_midstream");
        vec(1'b1, 4'h7, 4'h0, 16'h8001, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, "resume_b2b_1");
        vec(1'b1, 4'h6, 4'h0, 16'hFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, "resume_b2b_2");

        // Inputs switch to a taken jump just after the edge: outputs must hold.
        vec(1'b1, 4'h0, 4'h0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "latency_idle");
        @(posedge clk);
        #2;
        drive(1'b1, 4'h6, 4'h0, 16'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec(1'b1, 4'h6, 4'h0, 16'h1234, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, "latency_jmp");
        @(posedge clk);
        #2;
        drive(1'b1, 4'h5, 4'h0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Only the value present at the edge counts; earlier glitches are discarded.
        @(negedge clk);
        drive(1'b1, 4'h6, 4'h0, 16'h5555, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        drive(1'b1, 4'h7, 4'h0, 16'h5555, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out(1'b0, 16'h0000, "latency_last_value");
        vec(1'b1, 4'h0, 4'h0, 16'h0000, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "final_idle");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
